la5_gj_sequencer: RTL and testbench

- Gauss-Jordan elimination sequencer for the 5x5 matrix-inversion datapath.
- Walks pivot columns 0..N-1 and queries the datapath for nonzero pivot candidates.
- Issues row-operation commands (SWAP, NORM, ELIM) over a valid/ready handshake, then signals completion or singularity.
- The datapath owns matrix storage and arithmetic. This block owns only ordering and flow control.

---
 rtl/la5_gj_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_la5_gj_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la5_gj_sequencer.sv
// la5_gj_sequencer: pivot-ordering and command sequencer for Gauss-Jordan
// inversion of an N x N matrix. The datapath holds the matrix; this block
// searches for pivots and issues SWAP / NORM / ELIM row commands over valid/ready.
module la5_gj_sequencer #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          singular,
    output logic [IW-1:0] piv_rd_row,
    input  logic          piv_nz,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [1:0]    op_code,
    output logic [IW-1:0] op_pivot,
    output logic [IW-1:0] op_row
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] PRE_LAST = IW'(N - 2);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_TWO  = IW'(2);

    localparam logic [1:0] OP_NORM = 2'd0;
    localparam logic [1:0] OP_ELIM = 2'd1;
    localparam logic [1:0] OP_SWAP = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIND,
        S_SWAP,
        S_NORM,
        S_ELIM,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] k_q, k_d;         // pivot column / row
    logic [IW-1:0] j_q, j_d;         // row under test during the pivot search
    logic [IW-1:0] row_q, row_d;     // target row of the presented command
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          singular_q, singular_d;
    logic          op_valid_q, op_valid_d;
    logic [1:0]    op_code_q, op_code_d;

    logic [IW-1:0] elim_nxt;
    logic          elim_last;

    // Next-state, index and registered-output computation
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        j_d        = j_q;
        row_d      = row_q;
        singular_d = singular_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        op_valid_d = 1'b0;
        op_code_d  = op_code_q;

        // Next eliminated row skips the pivot row; last row depends on whether k is last
        elim_nxt  = row_q + IDX_ONE;
        if (elim_nxt == k_q) begin
            elim_nxt = row_q + IDX_TWO;
        end
        elim_last = (row_q == LAST_IDX) || ((row_q == PRE_LAST) && (k_q == LAST_IDX));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FIND;
                    k_d        = IDX_ZERO;
                    j_d        = IDX_ZERO;
                    singular_d = 1'b0;
                end
            end
            S_FIND: begin
                if (piv_nz) begin
                    if (j_q == k_q) begin
                        state_d = S_NORM;
                        row_d   = k_q;
                    end else begin
                        state_d = S_SWAP;
                        row_d   = j_q;
                    end
                end else if (j_q == LAST_IDX) begin
                    state_d    = S_FAIL;
                    singular_d = 1'b1;
                end else begin
                    j_d = j_q + IDX_ONE;
                end
            end
            S_SWAP: begin
                if (op_ready) begin
                    state_d = S_NORM;
                    row_d   = k_q;
                end
            end
            S_NORM: begin
                if (op_ready) begin
                    state_d = S_ELIM;
                    row_d   = (k_q == IDX_ZERO) ? IDX_ONE : IDX_ZERO;
                end
            end
            S_ELIM: begin
                if (op_ready) begin
                    if (elim_last) begin
                        state_d = S_NEXT;
                    end else begin
                        row_d = elim_nxt;
                    end
                end
            end
            S_NEXT: begin
                if (k_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FIND;
                    k_d     = k_q + IDX_ONE;
                    j_d     = k_q + IDX_ONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_FAIL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE) || (state_d == S_FAIL);
        unique case (state_d)
            S_SWAP: begin
                op_valid_d = 1'b1;
                op_code_d  = OP_SWAP;
            end
            S_NORM: begin
                op_valid_d = 1'b1;
                op_code_d  = OP_NORM;
            end
            S_ELIM: begin
                op_valid_d = 1'b1;
                op_code_d  = OP_ELIM;
            end
            default: op_valid_d = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= IDX_ZERO;
            j_q        <= IDX_ZERO;
            row_q      <= IDX_ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            singular_q <= 1'b0;
            op_valid_q <= 1'b0;
            op_code_q  <= OP_NORM;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            j_q        <= j_d;
            row_q      <= row_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            singular_q <= singular_d;
            op_valid_q <= op_valid_d;
            op_code_q  <= op_code_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign singular   = singular_q;
    assign piv_rd_row = j_q;
    assign op_valid   = op_valid_q;
    assign op_code    = op_code_q;
    assign op_pivot   = k_q;
    assign op_row     = row_q;

endmodule

// File: tb/tb_la5_gj_sequencer.sv
// Bench for la5_gj_sequencer: abstract datapath (per-column nonzero masks,
// swaps permute rows) plus a reference that lists the expected command stream.
module tb_la5_gj_sequencer;

    localparam int N  = 5;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          singular;
    logic [IW-1:0] piv_rd_row;
    logic          piv_nz;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op_code;
    logic [IW-1:0] op_pivot;
    logic [IW-1:0] op_row;

    la5_gj_sequencer #(.N(N), .IW(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .singular   (singular),
        .piv_rd_row (piv_rd_row),
        .piv_nz     (piv_nz),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_pivot   (op_pivot),
        .op_row     (op_row)
    );

    always #5 clk = ~clk;

    // mask[c][r]: element (r, c) is nonzero when column c is pivoted
    logic [7:0] mask  [0:7];
    logic [7:0] emask [0:7];
    assign piv_nz = mask[op_pivot][piv_rd_row];

    int   total = 0;
    int   bad   = 0;
    int   obs_q[$];
    int   exp_q[$];
    bit   exp_sing;
    int   mode;
    int   stall_left;
    int   stall_seen;
    bit   hit;
    bit   start_on_done;
    int   step_cnt;
    int   done_step;
    int   done_cnt;
    bit   saw_done;
    logic done_sing;
    int   busy_falls;
    logic prev_busy;
    bit   hold_v;
    logic [8:0] hold_f;

    localparam int C_NORM = 0;
    localparam int C_ELIM = 1;
    localparam int C_SWAP = 2;

    function automatic int enc(input int code, input int piv, input int row);
        return code * 64 + piv * 8 + row;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_identity();
        for (int c = 0; c < 8; c++) mask[c] = 8'(1 << c);
    endtask

    // Reference: Gauss-Jordan pivot search over the masks, listing every command
    task automatic build_expected();
        int piv;
        logic [7:0] t;
        exp_q.delete();
        exp_sing = 1'b0;
        for (int c = 0; c < 8; c++) emask[c] = mask[c];
        for (int k = 0; k < N; k++) begin
            piv = -1;
            for (int r = N - 1; r >= k; r--) if (emask[k][r]) piv = r;
            if (piv < 0) begin
                exp_sing = 1'b1;
                return;
            end
            if (piv != k) begin
                exp_q.push_back(enc(C_SWAP, k, piv));
                for (int c = 0; c < 8; c++) begin
                    t = emask[c];
                    emask[c][k]   = t[piv];
                    emask[c][piv] = t[k];
                end
            end
            exp_q.push_back(enc(C_NORM, k, k));
            for (int i = 0; i < N; i++) if (i != k) exp_q.push_back(enc(C_ELIM, k, i));
        end
    endtask

    // One clock: drive inputs and sample at negedge, apply swaps after the edge
    task automatic step(input bit st);
        bit   do_swap;
        int   sa, sb;
        logic [7:0] t;
        @(negedge clk);
        case (mode)
            1: op_ready = 1'($urandom_range(0, 1));
            2: begin
                if (op_valid && op_code == 2'd1 && op_pivot == 3'd1 && op_row == 3'd3 && stall_left > 0) begin
                    op_ready = 1'b0;
                    stall_left--;
                end else op_ready = 1'b1;
            end
            3: begin
                if (op_valid && op_code == 2'd1 && op_pivot == 3'd2 && op_row == 3'd4) begin
                    op_ready = 1'b0;
                    hit      = 1'b1;
                end else op_ready = 1'b1;
            end
            default: op_ready = 1'b1;
        endcase
        start = st || (start_on_done && done);
        step_cnt++;
        if (hold_v) begin
            chk("hold_valid", 32'(op_valid), 32'd1);
            chk("hold_fields", 32'({op_code, op_pivot, op_row}), 32'(hold_f));
        end
        hold_v = op_valid && !op_ready;
        hold_f = {op_code, op_pivot, op_row};
        if (op_valid && op_code == 2'd1 && op_pivot == 3'd1 && op_row == 3'd3) stall_seen++;
        if (prev_busy && !busy) busy_falls++;
        prev_busy = busy;
        if (done) begin
            done_cnt++;
            if (!saw_done) begin
                saw_done  = 1'b1;
                done_sing = singular;
                done_step = step_cnt;
            end
        end
        do_swap = 1'b0;
        sa = int'(op_pivot);
        sb = int'(op_row);
        if (op_valid && op_ready) begin
            obs_q.push_back(enc(int'(op_code), int'(op_pivot), int'(op_row)));
            do_swap = (op_code == 2'd2);
        end
        @(posedge clk);
        #1;
        if (do_swap) begin
            for (int c = 0; c < 8; c++) begin
                t = mask[c];
                mask[c][sa] = t[sb];
                mask[c][sb] = t[sa];
            end
        end
        start = 1'b0;
    endtask

    // Full run: start, wait for done (bounded), idle a few cycles, compare
    task automatic run_matrix(input string tag, input int md, input int pulse_at);
        int n;
        mode = md;
        build_expected();
        obs_q.delete();
        step_cnt   = 0;
        done_step  = 0;
        done_cnt   = 0;
        saw_done   = 1'b0;
        done_sing  = 1'bx;
        busy_falls = 0;
        prev_busy  = busy;
        hold_v     = 1'b0;
        step(1'b1);
        chk($sformatf("%s_busy_on_accept", tag), 32'(busy), 32'd1);
        chk($sformatf("%s_singular_cleared", tag), 32'(singular), 32'd0);
        for (int c = 0; c < 2000 && !saw_done; c++) step(c == pulse_at);
        chk($sformatf("%s_done_seen", tag), 32'(saw_done), 32'd1);
        for (int c = 0; c < 4; c++) step(1'b0);
        chk($sformatf("%s_singular", tag), 32'(done_sing), 32'(exp_sing));
        chk($sformatf("%s_singular_held", tag), 32'(singular), 32'(exp_sing));
        chk($sformatf("%s_done_pulses", tag), 32'(done_cnt), 32'd1);
        chk($sformatf("%s_busy_falls", tag), 32'(busy_falls), 32'd1);
        chk($sformatf("%s_busy_idle", tag), 32'(busy), 32'd0);
        chk($sformatf("%s_cmd_count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_cmd%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        if (md == 0 && !exp_sing && exp_q.size() == N * N)
            chk($sformatf("%s_latency", tag), 32'(done_step), 32'(1 + N * (N + 2) + 1));
        start_on_done = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        op_ready      = 1'b0;
        mode          = 0;
        hit           = 1'b0;
        stall_left    = 0;
        stall_seen    = 0;
        start_on_done = 1'b0;
        hold_v        = 1'b0;
        hold_f        = '0;
        set_identity();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_singular", 32'(singular), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_op_code", 32'(op_code), 32'd0);
        chk("rst_op_pivot", 32'(op_pivot), 32'd0);
        chk("rst_op_row", 32'(op_row), 32'd0);
        chk("rst_piv_rd_row", 32'(piv_rd_row), 32'd0);
        reset = 1'b0;

        // Identity, no back-pressure
        set_identity();
        chk("ident_expected_len", 32'(exp_q.size() + N * N), 32'(N * N));
        run_matrix("ident", 0, -1);

        // (0,0) zero, (1,0) nonzero: one swap at pivot 0
        set_identity();
        mask[0] = 8'b0000_0010;
        mask[1] = 8'b0000_0001;
        run_matrix("swap", 0, -1);

        // Column 2 has no candidate in rows 2..4: singular
        set_identity();
        mask[2] = 8'b0000_0011;
        run_matrix("fail", 0, -1);
        for (int i = 0; i < obs_q.size(); i++)
            chk("fail_no_pivot2", 32'((obs_q[i] / 8) % 8 == 2), 32'd0);

        // ELIM(1,3) held off for three cycles
        set_identity();
        stall_left = 3;
        stall_seen = 0;
        run_matrix("stall", 2, -1);
        chk("stall_cycles", 32'(stall_seen), 32'd4);

        // start while busy and during the done cycle is ignored
        set_identity();
        start_on_done = 1'b1;
        run_matrix("ignore", 0, 10);

        // Reset while ELIM(2,4) is stalled
        set_identity();
        mode = 3;
        hit  = 1'b0;
        step(1'b1);
        for (int c = 0; c < 500 && !hit; c++) step(1'b0);
        chk("rst_mid_hit", 32'(hit), 32'd1);
        @(negedge clk);
        reset  = 1'b1;
        hold_v = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_op_valid", 32'(op_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_op_row", 32'(op_row), 32'd0);
        mode = 0;
        step(1'b0);
        step(1'b0);
        chk("rst_mid_idle", 32'(busy), 32'd0);
        run_matrix("after_rst", 0, -1);

        // Random nonzero patterns with random back-pressure
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 8; c++) mask[c] = 8'(($urandom | $urandom) & 32'h1F);
            run_matrix($sformatf("rand%0d", r), 1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
